keypad_scan_ctrl: RTL
=====================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL provide parameter ROWS, default 4, number of keypad rows (2..8).
REQ-002 SHALL provide parameter COLS, default 4, number of keypad columns (2..8).
REQ-003 SHALL provide parameter SCAN_DIV, default 50000, clk cycles per scan tick (>=2).
REQ-004 SHALL provide parameter DEBOUNCE_SCANS, default 4, consecutive stable ticks for press/release acceptance (>=1).
REQ-005 SHALL provide parameter FIFO_DEPTH, default 4, key-event queue depth (power of 2, >=2).
REQ-006 SHALL provide parameter REPEAT_TICKS, default 64, ticks between auto-repeat events (used only under REQ-031).
REQ-007 SHALL provide port clk, input, 1, system clock, all logic on rising edge.
REQ-008 SHALL provide port rst, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL provide port row_in, input, ROWS, raw keypad rows, active-high, asynchronous to clk.
REQ-010 SHALL provide port col_out, output, COLS, one-hot column drive.
REQ-011 SHALL provide port key_valid, output, 1, FIFO non-empty.
REQ-012 SHALL provide port key_code, output, CODE_W = clog2(ROWS*COLS), FIFO head, code = row*COLS + col.
REQ-013 SHALL provide port key_ready, input, 1, consumer accepts head.
REQ-014 SHALL provide port key_held, output, 1, high while FSM in HELD.
REQ-015 SHALL provide port overflow, output, 1, one-cycle pulse when an event is dropped.

Function
REQ-016 SHALL synchronise row_in through two flops before any use.
REQ-017 SHALL generate a one-cycle tick every SCAN_DIV clk cycles from a free-running counter.
REQ-018 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-019 SCAN: on tick, if any synchronised row high, SHALL latch lowest-index high row and current column, clear debounce counter, go DEBOUNCE, freeze col_out; else rotate col_out one position (col COLS-1 wraps to col 0).
REQ-020 DEBOUNCE: on tick, latched row high SHALL increment counter; on reaching DEBOUNCE_SCANS SHALL push code and go HELD; latched row low SHALL return to SCAN and rotate column.
REQ-021 HELD: on tick with latched row low SHALL go RELEASE with counter cleared; other rows rising are ignored (no second key while held).
REQ-022 RELEASE: on tick, row low SHALL increment counter, at DEBOUNCE_SCANS go SCAN and rotate column; row high SHALL return to HELD without a new push.
REQ-023 key_valid SHALL assert on the clk cycle after the push edge; key_code SHALL be stable while key_valid high and key_ready low.
REQ-024 Pop SHALL occur when key_valid and key_ready both high on a clk edge.
REQ-025 Push while full and no pop SHALL drop the new event and pulse overflow for one cycle; FIFO contents unchanged.
REQ-026 Push and pop on the same edge while full SHALL both succeed, no overflow.
REQ-027 Push and pop on the same edge while empty impossible (key_valid low); push alone SHALL take effect.

Reset
REQ-028 rst low SHALL immediately force: FSM SCAN, col_out = one-hot column 0, key_valid 0, key_code 0, key_held 0, overflow 0, FIFO empty, tick and debounce counters 0, synchroniser flops 0.
REQ-029 Reset mid-press SHALL discard the partial debounce and all queued events; no event emitted on release after reset.
REQ-030 Release of rst SHALL be synchronised to clk before FSM leaves reset state.

Configuration
REQ-031 Macro KEYPAD_AUTO_REPEAT_EN defined: in HELD, SHALL push the latched code again every REPEAT_TICKS ticks after entry (first repeat REPEAT_TICKS ticks after the initial push), subject to REQ-025/026.
REQ-032 Macro KEYPAD_AUTO_REPEAT_EN undefined: exactly one push per accepted press; repeat counter and REPEAT_TICKS logic absent.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4 unless stated)
REQ-033 Reset then idle 100 cycles -> col_out cycles 0001,0010,0100,1000,0001 every 4 clk; key_valid 0.
REQ-034 Hold row 2 high only while col 1 driven, for 3 ticks -> one event key_code=9, key_held 1, col_out frozen 0010 until release accepted.
REQ-035 Row 2 high for 1 tick then low -> no event, FSM back to SCAN, column advances.
REQ-036 key_ready low, 5 distinct presses -> 4 events queued, overflow pulses once on 5th, then key_ready high pops codes in press order.
REQ-037 Assert rst during DEBOUNCE with key held -> key_valid 0, col_out 0001; no event after rst deasserts until key is released and re-pressed.
REQ-038 KEYPAD_AUTO_REPEAT_EN, REPEAT_TICKS=3, key held 10 ticks after acceptance -> initial event plus 3 repeats of same code.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: matrix keypad column scanner, row debouncer and key-event FIFO.
// Optional feature macro: KEYPAD_AUTO_REPEAT_EN (periodic re-push while a key is held).
module keypad_scan_ctrl #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_TICKS   = 64,
    localparam int CODE_W        = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row_in,
    output logic [COLS-1:0]   col_out,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overflow
);

    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int DW   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int RPW  = $clog2(REPEAT_TICKS + 1);
`endif

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    logic [1:0]        r_rst_sync;
    logic              w_run;
    logic [ROWS-1:0]   r_row_s1;
    logic [ROWS-1:0]   r_row_s2;
    logic [DIVW-1:0]   r_div;
    logic              w_tick;
    logic              w_row_any;
    logic [RW-1:0]     w_row_idx;
    logic              w_row_hit;

    state_t            r_state;
    logic [COLS-1:0]   r_col;
    logic [CW-1:0]     r_col_idx;
    logic [RW-1:0]     r_row_idx;
    logic [DW-1:0]     r_cnt;
    logic [DW-1:0]     w_cnt_inc;
    logic              r_held;
    logic              r_push;
    logic [CODE_W-1:0] r_push_code;
    logic              r_armed;
    logic [CW-1:0]     r_clean;
    logic [COLS-1:0]   w_col_rot;
    logic [CW-1:0]     w_col_idx_nxt;
    logic [CODE_W-1:0] w_code;
`ifdef KEYPAD_AUTO_REPEAT_EN
    logic [RPW-1:0]    r_rep;
    logic [RPW-1:0]    w_rep_inc;
`endif

    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [NW-1:0]     r_count;
    logic              r_ovf;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;

    // Reset release is retimed to clk; nothing advances until it has passed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= '0;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_run = r_rst_sync[1];

    // Two-flop synchroniser for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
        end else begin
            r_row_s1 <= row_in;
            r_row_s2 <= r_row_s1;
        end
    end

    // Free-running scan divider producing one tick every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_run) begin
            if (r_div == DIVW'(SCAN_DIV - 1)) r_div <= '0;
            else                              r_div <= r_div + 1'b1;
        end
    end

    assign w_tick = w_run && (r_div == DIVW'(SCAN_DIV - 1));

    // Lowest-index active row wins when several rows are high.
    always_comb begin
        w_row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (r_row_s2[i]) w_row_idx = RW'(i);
        end
    end

    assign w_row_any     = |r_row_s2;
    assign w_row_hit     = r_row_s2[r_row_idx];
    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_col_rot     = {r_col[COLS-2:0], r_col[COLS-1]};
    assign w_col_idx_nxt = (r_col_idx == CW'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
    assign w_code        = CODE_W'(r_row_idx) * CODE_W'(COLS) + CODE_W'(r_col_idx);
`ifdef KEYPAD_AUTO_REPEAT_EN
    assign w_rep_inc     = r_rep + 1'b1;
`endif

    // Scan/debounce FSM. After reset it stays disarmed until one full clean
    // column sweep, so a key still held through reset cannot emit an event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_SCAN;
            r_col       <= COLS'(1);
            r_col_idx   <= '0;
            r_row_idx   <= '0;
            r_cnt       <= '0;
            r_held      <= 1'b0;
            r_push      <= 1'b0;
            r_push_code <= '0;
            r_armed     <= 1'b0;
            r_clean     <= '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            r_rep       <= '0;
`endif
        end else begin
            r_push <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    S_SCAN: begin
                        if (w_row_any && r_armed) begin
                            r_row_idx <= w_row_idx;
                            r_cnt     <= '0;
                            r_state   <= S_DEBOUNCE;
                        end else begin
                            r_col     <= w_col_rot;
                            r_col_idx <= w_col_idx_nxt;
                            if (!r_armed) begin
                                if (w_row_any)                    r_clean <= '0;
                                else if (r_clean == CW'(COLS - 1)) r_armed <= 1'b1;
                                else                              r_clean <= r_clean + 1'b1;
                            end
                        end
                    end
                    S_DEBOUNCE: begin
                        if (w_row_hit) begin
                            if (w_cnt_inc == DW'(DEBOUNCE_SCANS)) begin
                                r_push      <= 1'b1;
                                r_push_code <= w_code;
                                r_held      <= 1'b1;
                                r_state     <= S_HELD;
`ifdef KEYPAD_AUTO_REPEAT_EN
                                r_rep       <= '0;
`endif
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_state   <= S_SCAN;
                            r_col     <= w_col_rot;
                            r_col_idx <= w_col_idx_nxt;
                        end
                    end
                    S_HELD: begin
                        if (!w_row_hit) begin
                            r_state <= S_RELEASE;
                            r_cnt   <= '0;
                            r_held  <= 1'b0;
                        end
`ifdef KEYPAD_AUTO_REPEAT_EN
                        else if (w_rep_inc == RPW'(REPEAT_TICKS)) begin
                            r_push      <= 1'b1;
                            r_push_code <= w_code;
                            r_rep       <= '0;
                        end else begin
                            r_rep <= w_rep_inc;
                        end
`endif
                    end
                    S_RELEASE: begin
                        if (!w_row_hit) begin
                            if (w_cnt_inc == DW'(DEBOUNCE_SCANS)) begin
                                r_state   <= S_SCAN;
                                r_col     <= w_col_rot;
                                r_col_idx <= w_col_idx_nxt;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_state <= S_HELD;
                            r_held  <= 1'b1;
`ifdef KEYPAD_AUTO_REPEAT_EN
                            r_rep   <= '0;
`endif
                        end
                    end
                    default: r_state <= S_SCAN;
                endcase
            end
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == NW'(FIFO_DEPTH));
    assign w_pop   = w_valid && key_ready;
    assign w_wr    = r_push && (!w_full || w_pop);

    // Event FIFO storage; a simultaneous pop frees room for a push when full.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_push_code;
    end

    // FIFO pointers, occupancy and the drop pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= r_push && !w_wr;
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign col_out   = r_col;
    assign key_valid = w_valid;
    assign key_code  = w_valid ? r_mem[r_rptr] : '0;
    assign key_held  = r_held;
    assign overflow  = r_ovf;

endmodule
